// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider beside the execute-stage ALU.
//   - DIV/MOD-class opcode encodings served by div_unit
//   - FSM state encodings (DIV_IDLE, DIV_CALC, DIV_FIX, DIV_DONE)
//   - DIV_ITERS: number of restoring iterations for a 32-bit operand
package div_unit_pkg;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  // Opcodes that the decoder steers to this unit.
  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,  // signed quotient
    OP_DIVU = 2'd1,  // unsigned quotient
    OP_REM  = 2'd2,  // signed remainder
    OP_REMU = 2'd3   // unsigned remainder
  } div_op_e;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step (purely combinational), reused every CALC cycle.
// Ports:
//   prem       in  WIDTH  current partial remainder (always < divisor)
//   in_bit     in  1      next dividend bit shifted in at the LSB
//   divisor    in  WIDTH  divisor magnitude
//   prem_next  out WIDTH  partial remainder after this step
//   q_bit      out 1      quotient bit produced by this step
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] prem,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] prem_next,
  output logic             q_bit
);

  // The shifted remainder can reach 2*divisor-1, which needs WIDTH+1 bits
  // once the divisor exceeds 2**(WIDTH-1); the extra bit keeps the trial
  // subtraction exact for every divisor.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {prem, in_bit};
  assign trial   = shifted - {1'b0, divisor};

  // Non-negative trial means the divisor fits: keep the difference.
  assign q_bit     = ~trial[WIDTH];
  assign prem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider with a fixed-latency start/busy/done
// handshake. The CPU stalls on busy; results and flags hold until the next
// operation writes them.
// Configuration macro: DIV_SIGNED_EN enables signed mode (abs on entry, sign
// fix-up in FIX, overflow flag). Without it all operands are unsigned and
// vout is constantly 0; latency is identical in both builds.
// Ports:
//   clk        in  1      system clock, rising edge
//   reset_b    in  1      asynchronous active-low reset
//   start      in  1      request, sampled only in IDLE
//   signed_op  in  1      1 = signed divide (DIV_SIGNED_EN builds only)
//   dividend   in  WIDTH  numerator, captured on accept
//   divisor    in  WIDTH  denominator, captured on accept
//   busy       out 1      high from the cycle after accept until done
//   done       out 1      one-cycle pulse; results valid from this cycle
//   quotient   out WIDTH  result
//   remainder  out WIDTH  result
//   dz         out 1      divide-by-zero flag
//   vout       out 1      signed overflow flag
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dz,
  output logic             vout
);

  div_state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] prem_q;   // partial remainder
  logic [WIDTH-1:0] shreg_q;  // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] dvsr_q;   // divisor magnitude

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [WIDTH-1:0] prem_next;
  logic             q_bit;
  logic             accept;
  logic             div_zero;
  logic             ovf_in;

  assign accept   = (state_q == DIV_IDLE) && start;
  assign div_zero = (divisor == '0);

`ifdef DIV_SIGNED_EN
  logic a_neg, b_neg;
  logic neg_q_q, neg_r_q;

  assign a_neg  = signed_op & dividend[WIDTH-1];
  assign b_neg  = signed_op & divisor[WIDTH-1];
  assign a_mag  = a_neg ? -dividend : dividend;
  assign b_mag  = b_neg ? -divisor : divisor;
  // Most-negative / -1: the magnitude path already yields the wrapped
  // quotient and a zero remainder; only the flag needs detecting.
  assign ovf_in = signed_op && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                  (divisor == '1);
  assign q_fix  = neg_q_q ? -shreg_q : shreg_q;
  assign r_fix  = neg_r_q ? -prem_q : prem_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (accept) begin
      neg_q_q <= a_neg ^ b_neg;
      neg_r_q <= a_neg;
    end
  end
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign a_mag  = dividend;
  assign b_mag  = divisor;
  assign ovf_in = 1'b0;
  assign q_fix  = shreg_q;
  assign r_fix  = prem_q;
`endif

  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .prem      (prem_q),
    .in_bit    (shreg_q[WIDTH-1]),
    .divisor   (dvsr_q),
    .prem_next (prem_next),
    .q_bit     (q_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= DIV_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      DIV_IDLE: begin
        if (start) state_d = div_zero ? DIV_DONE : DIV_CALC;
      end
      DIV_CALC: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        busy    = 1'b1;
        state_d = DIV_DONE;
      end
      DIV_DONE: begin
        done    = 1'b1;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cnt_q     <= '0;
      prem_q    <= '0;
      shreg_q   <= '0;
      dvsr_q    <= '0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
      vout      <= 1'b0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (start) begin
            if (div_zero) begin
              // Skip the iterations entirely; results are known at accept.
              quotient  <= '1;
              remainder <= dividend;
              dz        <= 1'b1;
              vout      <= 1'b0;
            end else begin
              cnt_q   <= CNT_W'(WIDTH - 1);
              prem_q  <= '0;
              shreg_q <= a_mag;
              dvsr_q  <= b_mag;
              vout    <= ovf_in;
            end
          end
        end
        DIV_CALC: begin
          prem_q  <= prem_next;
          shreg_q <= {shreg_q[WIDTH-2:0], q_bit};
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        DIV_FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          dz        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a table of operand/result records applied in a
// loop, plus hand-written sequences for re-pulsed start, start during DONE and
// reset mid-operation. Signed expectations follow DIV_SIGNED_EN.
`timescale 1ns/1ps
module tb_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_b = 1'b0;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, dz, vout;
  logic [W-1:0] quotient, remainder;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .start     (start),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz),
    .vout      (vout)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        edz;
    logic        ev;
    int          lat;
  } vec_t;

  int nvec = 0;
  int nmis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Drive a request at a negedge; returns at the cycle-1 sample point
  // (the accepting rising edge is cycle 0).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    signed_op = s;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done starting from sample cycle 'first'; counts cycles
  // where busy differs from exp_busy before done, and busy high during done.
  task automatic wait_done(input logic exp_busy, input int first,
                           output int dcyc, output int busy_err);
    dcyc     = -1;
    busy_err = 0;
    for (int c = first; c <= 80; c++) begin
      if (done) begin
        dcyc = c;
        if (busy) busy_err++;
        break;
      end
      if (busy !== exp_busy) busy_err++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int dcyc, berr;
    issue(v.a, v.b, v.s);
    wait_done(v.lat != 1, 1, dcyc, berr);
    check($sformatf("v%0d done_cycle", idx), dcyc, v.lat);
    check($sformatf("v%0d busy_pattern", idx), berr, 0);
    check($sformatf("v%0d quotient", idx), quotient, v.q);
    check($sformatf("v%0d remainder", idx), remainder, v.r);
    check($sformatf("v%0d dz", idx), {31'b0, dz}, {31'b0, v.edz});
    check($sformatf("v%0d vout", idx), {31'b0, vout}, {31'b0, v.ev});
    @(negedge clk);
    check($sformatf("v%0d done_one_cycle", idx), {31'b0, done}, 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    int dcyc, berr, stray;

    //            a             b             s     q             r             dz    v     lat
    vecs[0]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 1'b0, 34};
    vecs[1]  = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 34};
    vecs[2]  = '{32'd5,        32'd9,        1'b0, 32'd0,        32'd5,        1'b0, 1'b0, 34};
    vecs[3]  = '{32'h1234,     32'd0,        1'b0, 32'hFFFFFFFF, 32'h1234,     1'b1, 1'b0, 1};
    vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 32'd1,        32'd1,        1'b0, 1'b0, 34};
    vecs[5]  = '{32'd1000000,  32'd3,        1'b0, 32'd333333,   32'd1,        1'b0, 1'b0, 34};
    vecs[6]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 1'b0, 1'b0, 34};
    vecs[7]  = '{32'd0,        32'd0,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1};
`ifdef DIV_SIGNED_EN
    vecs[8]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 34};
    vecs[9]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 1'b1, 34};
    vecs[10] = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b0, 34};
    vecs[11] = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0, 34};
`else
    vecs[8]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'h7FFFFFFC, 32'd1,        1'b0, 1'b0, 34};
    vecs[9]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0,        32'h80000000, 1'b0, 1'b0, 34};
    vecs[10] = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'd0,        32'd7,        1'b0, 1'b0, 34};
    vecs[11] = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd0,        32'hFFFFFF9C, 1'b0, 1'b0, 34};
`endif

    // Reset state.
    #12;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset dz", {31'b0, dz}, 32'd0);
    check("reset vout", {31'b0, vout}, 32'd0);
    reset_b = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Start re-pulsed at cycle 10 with other operands must be ignored.
    issue(32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b1, 11, dcyc, berr);
    check("repulse done_cycle", dcyc, 34);
    check("repulse busy_pattern", berr, 0);
    check("repulse quotient", quotient, 32'd14);
    check("repulse remainder", remainder, 32'd2);

    // Start held during the DONE cycle of a divide-by-zero must be ignored.
    issue(32'd77, 32'd0, 1'b0);
    check("dz_fast done", {31'b0, done}, 32'd1);
    dividend = 32'd20;
    divisor  = 32'd4;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stray = 0;
    repeat (4) begin
      if (busy || done) stray++;
      @(negedge clk);
    end
    check("start_in_done ignored", stray, 0);
    check("start_in_done remainder", remainder, 32'd77);

    // Reset at cycle 15 aborts: outputs clear at once, no done pulse follows.
    issue(32'd100, 32'd7, 1'b0);
    repeat (14) @(negedge clk);
    reset_b = 1'b0;
    #1;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort quotient", quotient, 32'd0);
    check("abort remainder", remainder, 32'd0);
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || done) stray++;
    end
    reset_b = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (busy || done) stray++;
    end
    check("abort no_done", stray, 0);
    run_vec(99, vecs[5]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
